mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Parametrised load/store unit that replaces the combinational MEM stage of GeMIPS.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues one request at a time to the data-RAM controller over a req/ack handshake with arbitrary wait states, and stalls the pipeline until the access completes.
- Adds byte, halfword and word loads/stores, sign or zero extension, a selectable endian mode, misalignment detection and a bus timeout. Write-back outputs are registered.

Parameters:
- ADDR_W, 32, byte address width.
- REG_AW, 5, register-file address width.
- BIG_ENDIAN, 0, 0 = lane 0 is bits 7:0; 1 = lane 0 is bits 31:24.
- TIMEOUT, 255, cycles to wait for bus_ack_i before aborting; 0 = never time out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  EX presents an instruction this cycle.
- we_i  in  1  register write enable from EX.
- waddr_i  in  REG_AW  destination register.
- wdata_i  in  32  ALU result (non-memory ops).
- mem_op_i  in  8  memory operation code (package).
- mem_addr_i  in  ADDR_W  effective byte address.
- mem_data_i  in  32  store data (low bits significant).
- we_o  out  1  write enable to WB.
- waddr_o  out  REG_AW  destination register to WB.
- wdata_o  out  32  write-back data to WB.
- stall_o  out  1  hold IF/ID/EX and the EX/MEM register.
- bus_req_o  out  1  RAM request.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_addr_o  out  ADDR_W  word-aligned address (bits 1:0 = 0).
- bus_wdata_o  out  32  lane-replicated store data.
- bus_sel_o  out  4  byte enables, active-high.
- bus_ack_i  in  1  RAM completes the current request.
- bus_rdata_i  in  32  read data, valid with bus_ack_i.
- exc_o  out  1  one-cycle pulse: misaligned access or timeout.
- exc_code_o  out  2  1 = load misaligned, 2 = store misaligned, 3 = timeout.
- exc_addr_o  out  ADDR_W  faulting byte address, held until the next exception.

Behaviour:
- Reset (rst = 0, async): state IDLE, timeout counter 0, every output 0.
  - Reset in the middle of an access drops bus_req_o immediately and abandons the access; no write-back occurs.
- FSM states: IDLE, BUS, DONE.
- IDLE, valid_i with a non-memory op: on the next edge we_o/waddr_o/wdata_o <= we_i/waddr_i/wdata_i. Latency 1 cycle; stall_o stays 0.
- IDLE, valid_i with a memory op:
  - Alignment rules: LH, LHU and SH require addr[0] = 0; LW and SW require addr[1:0] = 0.
  - Misaligned: no bus access, we_o <= 0, exc_o pulses on the next cycle with the code and address, state stays IDLE.
  - Aligned: capture op, addr, data, waddr and we; go to BUS. stall_o = 1 combinationally in this cycle.
- BUS:
  - bus_req_o = 1, and bus_we_o/addr/wdata/sel are held stable until bus_ack_i is seen on a rising edge.
  - stall_o = 1; the counter increments each cycle.
  - On ack: go to DONE; loads capture the extracted, extended data.
  - Timeout: counter == TIMEOUT with no ack (TIMEOUT != 0) drops the request, pulses exc_o with code 3 and suppresses write-back; go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - Loads: we_o = captured we, wdata_o = load result.
  - Stores and aborted accesses: we_o = 0.
  - stall_o = 0, so EX advances in this same cycle. Next state is IDLE.
  - Minimum memory latency is 3 cycles with ack in the first BUS cycle.
- Byte enables: SB = 0001 << lane; SH = 0011 << (2*addr[1]); SW = 1111. Lane = addr[1:0], or its complement when BIG_ENDIAN.
- Store data: SB replicates the byte into 4 lanes; SH replicates the half into 2 halves; SW passes through.
- Load extraction: selects the lane(s) by the same mapping. LB/LH sign-extend; LBU/LHU zero-extend.
- bus_ack_i outside BUS is ignored.
- valid_i while not in IDLE is ignored (EX is held by stall_o).
- Output registers hold their values while stalled, except we_o, which is 0 in every cycle not following IDLE write-back or DONE.

Decomposition:
- Package mem_pkg:
  - mem_op codes: MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW.
  - FSM state encoding.
  - exc_code constants.
- One sub-module, mem_lane_align: combinational store replication, bus_sel generation, and load extraction/extension, parameterised by BIG_ENDIAN.

Test Plan:
- ALU op, valid_i, we_i = 1, waddr = 3, wdata = 0x1234 -> the next cycle shows we_o = 1, waddr_o = 3, wdata_o = 0x1234, and stall_o stays 0.
- LB at addr 0x103, ack after 2 wait cycles with rdata = 0x80FF_0000 -> bus_addr 0x100, sel 1000, stall_o high for 4 cycles, wdata_o = 0xFFFF_FF80. The same access with LBU -> wdata_o = 0x0000_0080.
- SH at 0x202 with data 0xABCD_1234 -> bus_we 1, sel 1100, wdata 0x1234_1234, we_o 0. With BIG_ENDIAN = 1 -> sel 0011.
- LW at 0x301 -> no bus_req, exc_o pulse with code 1 and exc_addr 0x301, we_o 0.
- TIMEOUT = 4 with no ack -> bus_req high for 5 cycles, then exc_o code 3 and no write-back. A second run with ack in the expiry cycle -> normal completion.
- Reset asserted during BUS -> bus_req_o and stall_o fall asynchronously. After release, an ALU op completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the GeMIPS load/store unit: op codes, FSM encoding,
// exception codes and small op-decode helpers.
package mem_pkg;

  localparam logic [7:0] MEM_NONE = 8'd0;
  localparam logic [7:0] MEM_LB   = 8'd1;
  localparam logic [7:0] MEM_LBU  = 8'd2;
  localparam logic [7:0] MEM_LH   = 8'd3;
  localparam logic [7:0] MEM_LHU  = 8'd4;
  localparam logic [7:0] MEM_LW   = 8'd5;
  localparam logic [7:0] MEM_SB   = 8'd6;
  localparam logic [7:0] MEM_SH   = 8'd7;
  localparam logic [7:0] MEM_SW   = 8'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] EXC_LD_MIS  = 2'd1;
  localparam logic [1:0] EXC_ST_MIS  = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_load(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    logic [1:0] sz;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: sz = SZ_HALF;
      MEM_LW, MEM_SW:          sz = SZ_WORD;
      default:                 sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    logic [1:0] sz;
    sz = op_size(op);
    return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and the pipeline:
// store replication, byte enables, load extraction and extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [7:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  localparam bit BE = (BIG_ENDIAN != 0);

  logic [1:0]  lane;
  logic        hidx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  assign lane = BE ? ~addr_i : addr_i;
  assign hidx = BE ? ~addr_i[1] : addr_i[1];
  assign sgn  = (op_i == MEM_LB) || (op_i == MEM_LH);

  always_comb begin
    byte_v    = rd_data_i[8*lane +: 8];
    half_v    = rd_data_i[16*hidx +: 16];
    sel_o     = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = rd_data_i;
    case (op_size(op_i))
      SZ_BYTE: begin
        sel_o     = 4'b0001 << lane;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sgn & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        sel_o     = 4'b0011 << {hidx, 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sgn & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle MEM stage: one req/ack bus access at a time, pipeline stall,
// registered write-back, misalignment and bus-timeout exceptions.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int REG_AW     = 5,
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic              we_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              exc_o,
  output logic [1:0]        exc_code_o,
  output logic [ADDR_W-1:0] exc_addr_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [REG_AW-1:0] rwaddr_q, rwaddr_d;
  logic              rwe_q, rwe_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              exc_q, exc_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;

  logic        in_mem, in_mis, in_bus;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_data;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op_i      (op_q),
    .addr_i    (addr_q[1:0]),
    .st_data_i (data_q),
    .rd_data_i (bus_rdata_i),
    .sel_o     (sel),
    .st_data_o (st_data),
    .ld_data_o (ld_data)
  );

  assign in_mem = is_load(mem_op_i) || is_store(mem_op_i);
  assign in_mis = misaligned(mem_op_i, mem_addr_i[1:0]);
  assign in_bus = (state_q == ST_BUS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rwaddr_d = rwaddr_q;
    rwe_d    = rwe_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    exc_d    = 1'b0;
    code_d   = code_q;
    eaddr_d  = eaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!in_mem) begin
            we_d    = we_i;
            waddr_d = waddr_i;
            wdata_d = wdata_i;
          end else if (in_mis) begin
            exc_d   = 1'b1;
            code_d  = is_store(mem_op_i) ? EXC_ST_MIS : EXC_LD_MIS;
            eaddr_d = mem_addr_i;
          end else begin
            op_d     = mem_op_i;
            addr_d   = mem_addr_i;
            data_d   = mem_data_i;
            rwaddr_d = waddr_i;
            rwe_d    = we_i;
            cnt_d    = '0;
            state_d  = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // ack takes priority over an expiring counter
        if (bus_ack_i) begin
          state_d = ST_DONE;
          if (is_load(op_q)) begin
            we_d    = rwe_q;
            waddr_d = rwaddr_q;
            wdata_d = ld_data;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
          state_d = ST_DONE;
          exc_d   = 1'b1;
          code_d  = EXC_TIMEOUT;
          eaddr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MEM_NONE;
      addr_q   <= '0;
      data_q   <= '0;
      rwaddr_q <= '0;
      rwe_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      exc_q    <= 1'b0;
      code_q   <= '0;
      eaddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rwaddr_q <= rwaddr_d;
      rwe_q    <= rwe_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      exc_q    <= exc_d;
      code_q   <= code_d;
      eaddr_q  <= eaddr_d;
    end
  end

  assign stall_o     = in_bus || ((state_q == ST_IDLE) && valid_i && in_mem && !in_mis);
  assign bus_req_o   = in_bus;
  assign bus_we_o    = in_bus && is_store(op_q);
  assign bus_addr_o  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_sel_o   = in_bus ? sel : 4'b0000;
  assign bus_wdata_o = (in_bus && is_store(op_q)) ? st_data : 32'd0;

  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign exc_o      = exc_q;
  assign exc_code_o = code_q;
  assign exc_addr_o = eaddr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: table of memory accesses with write-back/exception
// scoreboards, plus ALU, stray-ack and reset-during-access sequences.
module tb_mem_lsu;
  import mem_pkg::*;

  logic        clk, rst;
  logic        valid_i, we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i, mem_data_i, bus_rdata_i;
  logic [7:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic        bus_ack_i;

  logic        we_o, stall_o, bus_req_o, bus_we_o, exc_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o, exc_addr_o;
  logic [3:0]  bus_sel_o;
  logic [1:0]  exc_code_o;

  logic        be_we_o, be_stall_o, be_bus_req_o, be_bus_we_o, be_exc_o;
  logic [4:0]  be_waddr_o;
  logic [31:0] be_wdata_o, be_bus_addr_o, be_bus_wdata_o, be_exc_addr_o;
  logic [3:0]  be_bus_sel_o;
  logic [1:0]  be_exc_code_o;

  mem_lsu #(.ADDR_W(32), .REG_AW(5), .BIG_ENDIAN(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .exc_o(exc_o),
    .exc_code_o(exc_code_o), .exc_addr_o(exc_addr_o));

  mem_lsu #(.ADDR_W(32), .REG_AW(5), .BIG_ENDIAN(1), .TIMEOUT(4)) dut_be (
    .clk(clk), .rst(rst), .valid_i(valid_i), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .we_o(be_we_o), .waddr_o(be_waddr_o),
    .wdata_o(be_wdata_o), .stall_o(be_stall_o), .bus_req_o(be_bus_req_o),
    .bus_we_o(be_bus_we_o), .bus_addr_o(be_bus_addr_o),
    .bus_wdata_o(be_bus_wdata_o), .bus_sel_o(be_bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .exc_o(be_exc_o),
    .exc_code_o(be_exc_code_o), .exc_addr_o(be_exc_addr_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [36:0] wb_q[$];   // {waddr, wdata}
  logic [33:0] exc_q[$];  // {code, addr}

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, data, rdata;
    int          waits;     // -1: never ack
    int          exp_req;
    int          exp_stall;
    logic [3:0]  sel, sel_be;
    logic        bwe;
    logic [31:0] bwd;
    logic        wb;
    logic [31:0] wbd;
    logic [1:0]  exc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // advance one clock, then let the scoreboards consume any DUT output
  task automatic tick();
    logic [36:0] w;
    logic [33:0] e;
    @(posedge clk);
    #1;
    if (we_o) begin
      n_checks++;
      if (wb_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got waddr %0d data %h, expected none", waddr_o, wdata_o);
      end else begin
        w = wb_q.pop_front();
        if ({waddr_o, wdata_o} !== w) begin
          n_err++;
          $display("FAIL wb_data: got %0d/%h, expected %0d/%h", waddr_o, wdata_o, w[36:32], w[31:0]);
        end
      end
    end
    if (exc_o) begin
      n_checks++;
      if (exc_q.size() == 0) begin
        n_err++;
        $display("FAIL exc_unexpected: got code %0d addr %h, expected none", exc_code_o, exc_addr_o);
      end else begin
        e = exc_q.pop_front();
        if ({exc_code_o, exc_addr_o} !== e) begin
          n_err++;
          $display("FAIL exc: got %0d/%h, expected %0d/%h", exc_code_o, exc_addr_o, e[33:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stall_n, req_n;
    logic [3:0] sel, sel_be;
    logic [31:0] bwd, baddr;
    logic bwe, unstable;
    stall_n = 0; req_n = 0; unstable = 1'b0;
    sel = '0; sel_be = '0; bwd = '0; baddr = '0; bwe = 1'b0;
    if (v.wb) wb_q.push_back({5'(idx + 1), v.wbd});
    if (v.exc != 2'd0) exc_q.push_back({v.exc, v.addr});
    valid_i = 1'b1; we_i = 1'b1; waddr_i = 5'(idx + 1); wdata_i = 32'h5555_0000;
    mem_op_i = v.op; mem_addr_i = v.addr; mem_data_i = v.data;
    #1;
    if (stall_o) stall_n++;
    tick();
    valid_i = 1'b0; mem_op_i = MEM_NONE;
    for (int c = 0; c < 64; c++) begin
      if (!bus_req_o) break;
      if (c == 0) begin
        sel = bus_sel_o; sel_be = be_bus_sel_o; bwd = bus_wdata_o;
        bwe = bus_we_o; baddr = bus_addr_o;
      end else if ({sel, bwd, bwe, baddr} !== {bus_sel_o, bus_wdata_o, bus_we_o, bus_addr_o}) begin
        unstable = 1'b1;
      end
      req_n++;
      if (stall_o) stall_n++;
      bus_ack_i   = (v.waits >= 0) && (c == v.waits);
      bus_rdata_i = bus_ack_i ? v.rdata : $urandom;
      tick();
      bus_ack_i = 1'b0;
      if (c == 63) chk($sformatf("v%0d_bus_bound", idx), 32'd1, 32'd0);
    end
    chk($sformatf("v%0d_req_cycles", idx), 32'(req_n), 32'(v.exp_req));
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_n), 32'(v.exp_stall));
    chk($sformatf("v%0d_stall_done", idx), 32'(stall_o), 32'd0);
    if (v.exp_req > 0) begin
      chk($sformatf("v%0d_bus_addr", idx), baddr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_bus_sel", idx), 32'(sel), 32'(v.sel));
      chk($sformatf("v%0d_bus_sel_be", idx), 32'(sel_be), 32'(v.sel_be));
      chk($sformatf("v%0d_bus_we", idx), 32'(bwe), 32'(v.bwe));
      if (v.bwe) chk($sformatf("v%0d_bus_wdata", idx), bwd, v.bwd);
      chk($sformatf("v%0d_bus_stable", idx), 32'(unstable), 32'd0);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op       addr         data          rdata         w  req st sel      sel_be   bwe bwd           wb wbd           exc
    vecs[0]  = '{MEM_LB,  32'h103, 32'h0,         32'h80FF_0000, 2,  3, 4, 4'b1000, 4'b0001, 0, 32'h0,         1, 32'hFFFF_FF80, 2'd0};
    vecs[1]  = '{MEM_LBU, 32'h103, 32'h0,         32'h80FF_0000, 2,  3, 4, 4'b1000, 4'b0001, 0, 32'h0,         1, 32'h0000_0080, 2'd0};
    vecs[2]  = '{MEM_SH,  32'h202, 32'hABCD_1234, 32'h0,         0,  1, 2, 4'b1100, 4'b0011, 1, 32'h1234_1234, 0, 32'h0,         2'd0};
    vecs[3]  = '{MEM_LW,  32'h301, 32'h0,         32'h0,         0,  0, 0, 4'b0000, 4'b0000, 0, 32'h0,         0, 32'h0,         2'd1};
    vecs[4]  = '{MEM_SH,  32'h201, 32'h1,         32'h0,         0,  0, 0, 4'b0000, 4'b0000, 0, 32'h0,         0, 32'h0,         2'd2};
    vecs[5]  = '{MEM_LH,  32'h102, 32'h0,         32'h8001_7FFF, 1,  2, 3, 4'b1100, 4'b0011, 0, 32'h0,         1, 32'hFFFF_8001, 2'd0};
    vecs[6]  = '{MEM_LHU, 32'h100, 32'h0,         32'h8001_F00D, 0,  1, 2, 4'b0011, 4'b1100, 0, 32'h0,         1, 32'h0000_F00D, 2'd0};
    vecs[7]  = '{MEM_SB,  32'h301, 32'h0000_00A5, 32'h0,         1,  2, 3, 4'b0010, 4'b0100, 1, 32'hA5A5_A5A5, 0, 32'h0,         2'd0};
    vecs[8]  = '{MEM_SW,  32'h400, 32'hDEAD_BEEF, 32'h0,         3,  4, 5, 4'b1111, 4'b1111, 1, 32'hDEAD_BEEF, 0, 32'h0,         2'd0};
    vecs[9]  = '{MEM_LW,  32'h404, 32'h0,         32'h1234_5678, 0,  1, 2, 4'b1111, 4'b1111, 0, 32'h0,         1, 32'h1234_5678, 2'd0};
    vecs[10] = '{MEM_LB,  32'h100, 32'h0,         32'h0000_007F, 0,  1, 2, 4'b0001, 4'b1000, 0, 32'h0,         1, 32'h0000_007F, 2'd0};
    vecs[11] = '{MEM_LW,  32'h600, 32'h0,         32'h0,         -1, 5, 6, 4'b1111, 4'b1111, 0, 32'h0,         0, 32'h0,         2'd3};
    vecs[12] = '{MEM_LW,  32'h604, 32'h0,         32'hCAFE_F00D, 4,  5, 6, 4'b1111, 4'b1111, 0, 32'h0,         1, 32'hCAFE_F00D, 2'd0};
    vecs[13] = '{MEM_LH,  32'h203, 32'h0,         32'h0,         0,  0, 0, 4'b0000, 4'b0000, 0, 32'h0,         0, 32'h0,         2'd1};

    rst = 1'b0; valid_i = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    mem_op_i = MEM_NONE; mem_addr_i = '0; mem_data_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    #3;
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_exc", 32'({exc_o, exc_code_o}), 32'd0);
    chk("rst_exc_addr", exc_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // ALU op: one-cycle registered write-back, no stall
    wb_q.push_back({5'd3, 32'h0000_1234});
    valid_i = 1'b1; we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h1234; mem_op_i = MEM_NONE;
    #1;
    chk("alu_stall", 32'(stall_o), 32'd0);
    tick();
    valid_i = 1'b0;
    chk("alu_we", 32'(we_o), 32'd1);
    tick();
    chk("alu_we_drop", 32'(we_o), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // stray ack while idle must not start or complete anything
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    chk("idle_ack_req", 32'(bus_req_o), 32'd0);
    chk("idle_ack_we", 32'(we_o), 32'd0);

    // reset during BUS abandons the access
    valid_i = 1'b1; we_i = 1'b1; waddr_i = 5'd9; mem_op_i = MEM_LW; mem_addr_i = 32'h500;
    tick();
    valid_i = 1'b0; mem_op_i = MEM_NONE;
    chk("rstmid_req_before", 32'(bus_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_req", 32'(bus_req_o), 32'd0);
    chk("rstmid_stall", 32'(stall_o), 32'd0);
    chk("rstmid_wdata", wdata_o, 32'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    tick();
    bus_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("rstmid_no_wb", 32'(we_o), 32'd0);
    wb_q.push_back({5'd7, 32'h0000_BEEF});
    valid_i = 1'b1; we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'hBEEF; mem_op_i = MEM_NONE;
    tick();
    valid_i = 1'b0;
    chk("post_rst_alu_we", 32'(we_o), 32'd1);
    tick();

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
